// File: rtl/sap1_controller.sv
// sap1_controller: T-state ring sequencer and control-word decoder for the SAP-1 datapath
module sap1_controller #(
    parameter int OP_W       = 4,
    parameter bit FAST_CYCLE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OP_W-1:0] opcode,
    output logic [5:0]      t_state,
    output logic            pc_inc,
    output logic            pc_en,
    output logic            mar_load,
    output logic            ram_en,
    output logic            ir_load,
    output logic            ir_en,
    output logic            a_load,
    output logic            a_en,
    output logic            b_load,
    output logic            alu_sub,
    output logic            alu_en,
    output logic            out_load,
    output logic            halted
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;
    logic    is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic    alu_op, mem_op, act, end_early;
    logic    t1, t2, t3, t4, t5, t6;

    assign is_lda = opcode == OP_LDA;
    assign is_add = opcode == OP_ADD;
    assign is_sub = opcode == OP_SUB;
    assign is_out = opcode == OP_OUT;
    assign is_hlt = opcode == OP_HLT;
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    assign alu_op = is_add || is_sub;
    assign mem_op = is_lda || alu_op;

    assign t1 = state_q == T1;
    assign t2 = state_q == T2;
    assign t3 = state_q == T3;
    assign t4 = state_q == T4;
    assign t5 = state_q == T5;
    assign t6 = state_q == T6;

    // Strobes only fire while the machine is live; reset forces them low even before the flops clear
    assign act = !rst && run && !halted_q;

    // Short instructions skip their idle tail states when the fast cycle is enabled
    assign end_early = FAST_CYCLE && ((t3 && is_nop) || (t4 && is_out) || (t5 && is_lda));

    // Next-state: rotate the ring, park on HLT at T4, or return to T1 early
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (run && !halted_q) begin
            if (t4 && is_hlt)
                halted_d = 1'b1;
            else
                state_d = end_early ? T1 : tstate_e'({state_q[4:0], state_q[5]});
        end
    end

    // Sequencer state with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign t_state  = state_q;
    assign halted   = halted_q;

    // Control word: fetch in T1..T3, execute decoded from the opcode in T4..T6
    assign pc_en    = act && t1;
    assign pc_inc   = act && t2;
    assign ir_load  = act && t3;
    assign mar_load = act && (t1 || (t4 && mem_op));
    assign ram_en   = act && (t3 || (t5 && mem_op));
    assign ir_en    = act && t4 && mem_op;
    assign a_load   = act && ((t5 && is_lda) || (t6 && alu_op));
    assign b_load   = act && t5 && alu_op;
    assign alu_sub  = act && (t5 || t6) && is_sub;
    assign alu_en   = act && t6 && alu_op;
    assign a_en     = act && t4 && is_out;
    assign out_load = act && t4 && is_out;
endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: scoreboard bench for the SAP-1 sequencer in both cycle modes
module tb_sap1_controller;
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] LB = 12'h008, SU = 12'h004, EU = 12'h002, LO = 12'h001;

    typedef struct {
        bit          sel;
        logic [5:0]  ts;
        logic [11:0] cw;
        logic        h;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, run, rnd;
    logic [3:0]  opcode;
    logic [5:0]  ts_s, ts_f, a_ts;
    logic [11:0] cw_s, cw_f, a_cw;
    logic        h_s, h_f, a_h;
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sap1_controller #(.OP_W(4), .FAST_CYCLE(1'b0)) u_slow (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .t_state(ts_s),
        .pc_inc(cw_s[11]), .pc_en(cw_s[10]), .mar_load(cw_s[9]), .ram_en(cw_s[8]),
        .ir_load(cw_s[7]), .ir_en(cw_s[6]), .a_load(cw_s[5]), .a_en(cw_s[4]),
        .b_load(cw_s[3]), .alu_sub(cw_s[2]), .alu_en(cw_s[1]), .out_load(cw_s[0]),
        .halted(h_s)
    );

    sap1_controller #(.OP_W(4), .FAST_CYCLE(1'b1)) u_fast (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .t_state(ts_f),
        .pc_inc(cw_f[11]), .pc_en(cw_f[10]), .mar_load(cw_f[9]), .ram_en(cw_f[8]),
        .ir_load(cw_f[7]), .ir_en(cw_f[6]), .a_load(cw_f[5]), .a_en(cw_f[4]),
        .b_load(cw_f[3]), .alu_sub(cw_f[2]), .alu_en(cw_f[1]), .out_load(cw_f[0]),
        .halted(h_f)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit sel, input logic [5:0] ts, input logic [11:0] cw,
                       input logic h, input string tag);
        exp_t x;
        x.sel = sel;
        x.ts  = ts;
        x.cw  = cw;
        x.h   = h;
        x.tag = tag;
        sb.push_back(x);
        tick();
    endtask

    task automatic reset_pulse(input bit sel);
        rst = 1'b1;
        cyc(sel, 6'h01, 12'h000, 1'b0, "reset");
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per cycle and compares it mid-cycle
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            a_ts = e.sel ? ts_f : ts_s;
            a_cw = e.sel ? cw_f : cw_s;
            a_h  = e.sel ? h_f : h_s;
            checks += 3;
            if (a_ts !== e.ts) begin
                errors++;
                $display("FAIL %s t_state: got %h expected %h", e.tag, a_ts, e.ts);
            end
            if (a_cw !== e.cw) begin
                errors++;
                $display("FAIL %s control: got %h expected %h", e.tag, a_cw, e.cw);
            end
            if (a_h !== e.h) begin
                errors++;
                $display("FAIL %s halted: got %b expected %b", e.tag, a_h, e.h);
            end
        end
        if (rnd) begin
            checks += 2;
            if ($countones({cw_s[10], cw_s[8], cw_s[6], cw_s[4], cw_s[1]}) > 1) begin
                errors++;
                $display("FAIL bus_slow: drivers %h expected at most one", cw_s);
            end
            if ($countones({cw_f[10], cw_f[8], cw_f[6], cw_f[4], cw_f[1]}) > 1) begin
                errors++;
                $display("FAIL bus_fast: drivers %h expected at most one", cw_f);
            end
            if (rst) begin
                checks += 2;
                if (cw_s !== 12'h000 || ts_s !== 6'h01 || h_s !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_slow: cw %h ts %h h %b expected 000 01 0", cw_s, ts_s, h_s);
                end
                if (cw_f !== 12'h000 || ts_f !== 6'h01 || h_f !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_fast: cw %h ts %h h %b expected 000 01 0", cw_f, ts_f, h_f);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        run    = 1'b1;
        rnd    = 1'b0;
        opcode = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 6'h01, 12'h000, 1'b0, "rst_hold_slow");
        cyc(1, 6'h01, 12'h000, 1'b0, "rst_hold_fast");
        rst = 1'b0;
        // LDA, full six-state cycle
        cyc(0, 6'h01, EP | LM, 1'b0, "lda_t1");
        cyc(0, 6'h02, CP,      1'b0, "lda_t2");
        cyc(0, 6'h04, CE | LI, 1'b0, "lda_t3");
        cyc(0, 6'h08, EI | LM, 1'b0, "lda_t4");
        cyc(0, 6'h10, CE | LA, 1'b0, "lda_t5");
        cyc(0, 6'h20, 12'h000, 1'b0, "lda_t6");
        cyc(0, 6'h01, EP | LM, 1'b0, "lda_wrap");
        // ADD
        reset_pulse(0);
        opcode = 4'h1;
        cyc(0, 6'h01, EP | LM, 1'b0, "add_t1");
        cyc(0, 6'h02, CP,      1'b0, "add_t2");
        cyc(0, 6'h04, CE | LI, 1'b0, "add_t3");
        cyc(0, 6'h08, EI | LM, 1'b0, "add_t4");
        cyc(0, 6'h10, CE | LB, 1'b0, "add_t5");
        cyc(0, 6'h20, EU | LA, 1'b0, "add_t6");
        cyc(0, 6'h01, EP | LM, 1'b0, "add_wrap");
        // SUB
        reset_pulse(0);
        opcode = 4'h2;
        cyc(0, 6'h01, EP | LM,      1'b0, "sub_t1");
        cyc(0, 6'h02, CP,           1'b0, "sub_t2");
        cyc(0, 6'h04, CE | LI,      1'b0, "sub_t3");
        cyc(0, 6'h08, EI | LM,      1'b0, "sub_t4");
        cyc(0, 6'h10, CE | LB | SU, 1'b0, "sub_t5");
        cyc(0, 6'h20, EU | LA | SU, 1'b0, "sub_t6");
        // OUT, fast cycle
        reset_pulse(1);
        opcode = 4'hE;
        cyc(1, 6'h01, EP | LM, 1'b0, "outf_t1");
        cyc(1, 6'h02, CP,      1'b0, "outf_t2");
        cyc(1, 6'h04, CE | LI, 1'b0, "outf_t3");
        cyc(1, 6'h08, EA | LO, 1'b0, "outf_t4");
        cyc(1, 6'h01, EP | LM, 1'b0, "outf_ret");
        // LDA, fast cycle
        reset_pulse(1);
        opcode = 4'h0;
        cyc(1, 6'h01, EP | LM, 1'b0, "ldaf_t1");
        cyc(1, 6'h02, CP,      1'b0, "ldaf_t2");
        cyc(1, 6'h04, CE | LI, 1'b0, "ldaf_t3");
        cyc(1, 6'h08, EI | LM, 1'b0, "ldaf_t4");
        cyc(1, 6'h10, CE | LA, 1'b0, "ldaf_t5");
        cyc(1, 6'h01, EP | LM, 1'b0, "ldaf_ret");
        // NOP, fast cycle
        reset_pulse(1);
        opcode = 4'h7;
        cyc(1, 6'h01, EP | LM, 1'b0, "nopf_t1");
        cyc(1, 6'h02, CP,      1'b0, "nopf_t2");
        cyc(1, 6'h04, CE | LI, 1'b0, "nopf_t3");
        cyc(1, 6'h01, EP | LM, 1'b0, "nopf_ret");
        // HLT, then run ignored, then async reset clears it
        reset_pulse(0);
        opcode = 4'hF;
        cyc(0, 6'h01, EP | LM, 1'b0, "hlt_t1");
        cyc(0, 6'h02, CP,      1'b0, "hlt_t2");
        cyc(0, 6'h04, CE | LI, 1'b0, "hlt_t3");
        cyc(0, 6'h08, 12'h000, 1'b0, "hlt_t4");
        for (int i = 0; i < 10; i++) begin
            run = 1'($urandom_range(0, 1));
            cyc(0, 6'h08, 12'h000, 1'b1, "halted");
        end
        run = 1'b1;
        reset_pulse(0);
        run = 1'b0;
        cyc(0, 6'h01, 12'h000, 1'b0, "post_rst_idle");
        run = 1'b1;
        cyc(0, 6'h01, EP | LM, 1'b0, "post_rst_t1");
        cyc(0, 6'h02, CP,      1'b0, "post_rst_t2");
        // run dropped during T5 of LDA
        reset_pulse(0);
        opcode = 4'h0;
        cyc(0, 6'h01, EP | LM, 1'b0, "pause_t1");
        cyc(0, 6'h02, CP,      1'b0, "pause_t2");
        cyc(0, 6'h04, CE | LI, 1'b0, "pause_t3");
        cyc(0, 6'h08, EI | LM, 1'b0, "pause_t4");
        run = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 6'h10, 12'h000, 1'b0, "paused_t5");
        run = 1'b1;
        cyc(0, 6'h10, CE | LA, 1'b0, "resume_t5");
        cyc(0, 6'h20, 12'h000, 1'b0, "resume_t6");
        cyc(0, 6'h01, EP | LM, 1'b0, "resume_wrap");
        // Random opcodes with random run and reset
        rnd = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            opcode = 4'($urandom);
            run    = ($urandom % 8) != 0;
            rst    = ($urandom % 50) == 0;
            tick();
        end
        rst = 1'b0;
        rnd = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
Control sequencer for the SAP-1 datapath: PC, MAR, RAM, IR, accumulator A, register B, ALU and output register. A T-state ring counter, decoded against the IR opcode, drives the per-cycle control word (load/enable strobes) onto the shared 8-bit bus. Sits beside the IR at the top level and is the only source of register load/enable signals.

Parameters:
OP_W, 4, opcode width (IR upper nibble).
FAST_CYCLE, 0, 0 = every instruction takes T1..T6; 1 = instruction ends after its last active T-state.

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = sequencer advances; 0 = state frozen, control word forced to 0
opcode  in  OP_W  IR upper nibble, sampled combinationally in T4..T6
t_state  out  6  one-hot current T-state (bit0 = T1)
pc_inc  out  1  Cp: PC increment
pc_en  out  1  Ep: PC drives bus
mar_load  out  1  Lm: MAR loads from bus
ram_en  out  1  CE: RAM drives bus
ir_load  out  1  Li: IR loads from bus
ir_en  out  1  Ei: IR lower nibble drives bus
a_load  out  1  La: A loads from bus
a_en  out  1  Ea: A drives bus
b_load  out  1  Lb: B loads from bus
alu_sub  out  1  Su: ALU subtract (0 = add)
alu_en  out  1  Eu: ALU drives bus
out_load  out  1  Lo: output register loads from bus
halted  out  1  sequencer stopped by HLT

Behaviour:
- Reset: async. t_state=6'b000001 (T1), halted=0. All control outputs 0 while rst=1, regardless of state.
- Control word is combinational from t_state, opcode, run, halted. Consumers act on the next posedge.
- State advance per posedge when run=1 and halted=0: T1->T2->...->T6->T1. run=0: hold state.
- Fetch (all opcodes): T1 pc_en,mar_load; T2 pc_inc; T3 ram_en,ir_load.
- Opcodes:
  - LDA 0000: T4 ir_en,mar_load; T5 ram_en,a_load; T6 none.
  - ADD 0001: T4 ir_en,mar_load; T5 ram_en,b_load; T6 alu_en,a_load (alu_sub=0).
  - SUB 0010: as ADD, but alu_sub=1 in T5 and T6.
  - OUT 1110: T4 a_en,out_load; T5,T6 none.
  - HLT 1111: T4 none. On the T4 posedge, halted<=1 and the state holds at T4.
  - Any other opcode is NOP: T4..T6 none.
- FAST_CYCLE=1: T6->T1 unchanged. Early return to T1 from T5 for LDA, from T4 for OUT, from T3 for NOP. For NOP, opcode is evaluated in T3 after ir_load, using the IR value already present.
- At most one bus driver (pc_en, ram_en, ir_en, a_en, alu_en) is high in any cycle. This is an invariant.
- halted=1: all control outputs 0, t_state frozen. Only rst clears it. run is ignored.
- rst asserted mid-instruction: state and halted clear immediately (asynchronous). Outputs go to 0 in the same cycle. After rst deasserts, the first posedge with run=1 moves T1->T2.
- run deasserted mid-instruction: resume at the same T-state with the same control word once run=1.

Test Plan:
- Reset then run=1, opcode=0000, FAST_CYCLE=0 -> t_state 01,02,04,08,10,20,01 on successive edges; pc_en&mar_load only in T1, pc_inc only in T2, ram_en&ir_load only in T3.
- ADD (0001) in T4..T6 -> T4 ir_en,mar_load; T5 ram_en,b_load; T6 alu_en,a_load with alu_sub=0. Repeat with SUB (0010) -> alu_sub=1 in T5/T6.
- OUT (1110) with FAST_CYCLE=1 -> a_en,out_load in T4, next state T1. LDA -> returns to T1 after T5. Opcode 0111 -> returns to T1 after T3.
- HLT (1111) at T4 -> halted=1 after the edge; 10 further cycles show t_state=08 and all controls 0. Pulse rst -> halted=0, t_state=01.
- run=0 during T5 of LDA for 3 cycles -> t_state stays 10 and controls are 0. run=1 -> ram_en,a_load asserted, then T6.
- Random opcodes over 1000 cycles with random run/rst -> at most one bus enable per cycle; no output high while rst=1.
